// File: rtl/de_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : de_pipe_reg
// Description : Decode-to-execute pipeline register for the RV32 core.
//               Captures the decoded payload with a valid/ready handshake,
//               resolves operand forwarding at capture time and supports
//               flush and bubble insertion.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Configuration macro:
//   DE_PERF_CNT_EN - when defined, stall_cnt/flush_cnt are saturating 32-bit
//                    performance counters; otherwise both read 0 and no
//                    counter flops exist.
// ----------------------------------------------------------------------------
// Ports:
//   clk, rst_n                   core clock, asynchronous active-low reset
//   in_valid / in_ready          decode-side handshake
//   out_valid / out_ready        execute-side handshake
//   flush                        kill held and incoming instruction
//   *_in / *_out                 instruction payload (pc, opcode, rd, funct3,
//                                funct7, rs1/rs2 addr, imm, op sels, jal/jalr)
//   rs1_data_in, rs2_data_in     register-file read data
//   fwd_sel1, fwd_sel2           00 regfile, 01 alu_mem, 10 wb, 11 regfile
//   alu_mem_data, wb_data        forwarding sources
//   rs1_data_out, rs2_data_out   forwarded operands
//   stall_cnt, flush_cnt         performance counters
// ============================================================================
module de_pipe_reg #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int OPCODE_W   = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic                  flush,
  input  logic [XLEN-1:0]       pc_in,
  output logic [XLEN-1:0]       pc_out,
  input  logic [OPCODE_W-1:0]   opcode_in,
  output logic [OPCODE_W-1:0]   opcode_out,
  input  logic [REG_ADDR_W-1:0] rd_addr_in,
  output logic [REG_ADDR_W-1:0] rd_addr_out,
  input  logic [2:0]            funct3_in,
  output logic [2:0]            funct3_out,
  input  logic [6:0]            funct7_in,
  output logic [6:0]            funct7_out,
  input  logic [REG_ADDR_W-1:0] rs1_addr_in,
  output logic [REG_ADDR_W-1:0] rs1_addr_out,
  input  logic [REG_ADDR_W-1:0] rs2_addr_in,
  output logic [REG_ADDR_W-1:0] rs2_addr_out,
  input  logic [XLEN-1:0]       rs1_data_in,
  input  logic [XLEN-1:0]       rs2_data_in,
  input  logic [XLEN-1:0]       imm_in,
  output logic [XLEN-1:0]       imm_out,
  input  logic [1:0]            op1_sel_in,
  output logic [1:0]            op1_sel_out,
  input  logic [1:0]            op2_sel_in,
  output logic [1:0]            op2_sel_out,
  input  logic [1:0]            fwd_sel1,
  input  logic [1:0]            fwd_sel2,
  input  logic [XLEN-1:0]       alu_mem_data,
  input  logic [XLEN-1:0]       wb_data,
  input  logic                  jal_en_in,
  output logic                  jal_en_out,
  input  logic                  jalr_en_in,
  output logic                  jalr_en_out,
  output logic [XLEN-1:0]       rs1_data_out,
  output logic [XLEN-1:0]       rs2_data_out,
  output logic [31:0]           stall_cnt,
  output logic [31:0]           flush_cnt
);

  localparam logic [1:0] c_FWD_ALU_MEM = 2'b01;
  localparam logic [1:0] c_FWD_WB      = 2'b10;

  // Registered state
  logic                  valid_q;
  logic [XLEN-1:0]       pc_q;
  logic [OPCODE_W-1:0]   opcode_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [2:0]            funct3_q;
  logic [6:0]            funct7_q;
  logic [REG_ADDR_W-1:0] rs1_addr_q;
  logic [REG_ADDR_W-1:0] rs2_addr_q;
  logic [XLEN-1:0]       rs1_data_q;
  logic [XLEN-1:0]       rs2_data_q;
  logic [XLEN-1:0]       imm_q;
  logic [1:0]            op1_sel_q;
  logic [1:0]            op2_sel_q;
  logic                  jal_q;
  logic                  jalr_q;

  // Next-state values
  logic                  w_accept;
  logic                  valid_d;
  logic [REG_ADDR_W-1:0] rd_d;
  logic                  jal_d;
  logic                  jalr_d;
  logic [XLEN-1:0]       rs1_fwd_d;
  logic [XLEN-1:0]       rs2_fwd_d;

  // Forward mux; the unused encoding 11 falls back to the register file.
  function automatic logic [XLEN-1:0] fwd_mux(
    input logic [1:0]      sel,
    input logic [XLEN-1:0] rf,
    input logic [XLEN-1:0] am,
    input logic [XLEN-1:0] wb
  );
    logic [XLEN-1:0] res;
    res = rf;
    if (sel == c_FWD_ALU_MEM) res = am;
    else if (sel == c_FWD_WB) res = wb;
    return res;
  endfunction

  assign in_ready = !valid_q || out_ready;

  always_comb begin
    w_accept  = in_valid && in_ready && !flush;
    rs1_fwd_d = fwd_mux(fwd_sel1, rs1_data_in, alu_mem_data, wb_data);
    rs2_fwd_d = fwd_mux(fwd_sel2, rs2_data_in, alu_mem_data, wb_data);

    // Flush wins over everything; otherwise a consumed entry with nothing
    // new behind it becomes a bubble.
    valid_d = valid_q;
    if (flush)         valid_d = 1'b0;
    else if (w_accept) valid_d = 1'b1;
    else if (out_ready) valid_d = 1'b0;

    // Side-effecting fields are cleared in the register whenever the slot
    // becomes empty, so a bubble can never write rd or redirect the PC.
    if (w_accept) begin
      rd_d   = rd_addr_in;
      jal_d  = jal_en_in;
      jalr_d = jalr_en_in;
    end else if (valid_d) begin
      rd_d   = rd_q;
      jal_d  = jal_q;
      jalr_d = jalr_q;
    end else begin
      rd_d   = '0;
      jal_d  = 1'b0;
      jalr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      opcode_q   <= '0;
      rd_q       <= '0;
      funct3_q   <= '0;
      funct7_q   <= '0;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      op1_sel_q  <= '0;
      op2_sel_q  <= '0;
      jal_q      <= 1'b0;
      jalr_q     <= 1'b0;
    end else begin
      valid_q <= valid_d;
      rd_q    <= rd_d;
      jal_q   <= jal_d;
      jalr_q  <= jalr_d;
      // Remaining payload only moves on accept; flushed entries may keep
      // stale values since they are qualified by out_valid downstream.
      if (w_accept) begin
        pc_q       <= pc_in;
        opcode_q   <= opcode_in;
        funct3_q   <= funct3_in;
        funct7_q   <= funct7_in;
        rs1_addr_q <= rs1_addr_in;
        rs2_addr_q <= rs2_addr_in;
        rs1_data_q <= rs1_fwd_d;
        rs2_data_q <= rs2_fwd_d;
        imm_q      <= imm_in;
        op1_sel_q  <= op1_sel_in;
        op2_sel_q  <= op2_sel_in;
      end
    end
  end

  assign out_valid    = valid_q;
  assign pc_out       = pc_q;
  assign opcode_out   = opcode_q;
  assign rd_addr_out  = rd_q;
  assign funct3_out   = funct3_q;
  assign funct7_out   = funct7_q;
  assign rs1_addr_out = rs1_addr_q;
  assign rs2_addr_out = rs2_addr_q;
  assign rs1_data_out = rs1_data_q;
  assign rs2_data_out = rs2_data_q;
  assign imm_out      = imm_q;
  assign op1_sel_out  = op1_sel_q;
  assign op2_sel_out  = op2_sel_q;
  assign jal_en_out   = jal_q;
  assign jalr_en_out  = jalr_q;

`ifdef DE_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      // Both counters saturate rather than wrap.
      if (valid_q && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF))
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush && (valid_q || in_valid) && (flush_cnt_q != 32'hFFFF_FFFF))
        flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_de_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_de_pipe_reg
// Description : Scoreboard bench for de_pipe_reg. Stimulus pushes the
//               expected execute-side payload on acceptance; a monitor pops
//               and compares whenever a payload is consumed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_de_pipe_reg;

`ifdef DE_PERF_CNT_EN
  localparam bit c_PERF = 1'b1;
`else
  localparam bit c_PERF = 1'b0;
`endif

  logic        clk, rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, flush;
  logic [31:0] pc_in, pc_out;
  logic [6:0]  opcode_in, opcode_out;
  logic [4:0]  rd_addr_in, rd_addr_out;
  logic [2:0]  funct3_in, funct3_out;
  logic [6:0]  funct7_in, funct7_out;
  logic [4:0]  rs1_addr_in, rs1_addr_out, rs2_addr_in, rs2_addr_out;
  logic [31:0] rs1_data_in, rs2_data_in, imm_in, imm_out;
  logic [1:0]  op1_sel_in, op1_sel_out, op2_sel_in, op2_sel_out;
  logic [1:0]  fwd_sel1, fwd_sel2;
  logic [31:0] alu_mem_data, wb_data;
  logic        jal_en_in, jal_en_out, jalr_en_in, jalr_en_out;
  logic [31:0] rs1_data_out, rs2_data_out, stall_cnt, flush_cnt;

  de_pipe_reg dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .flush(flush),
    .pc_in(pc_in), .pc_out(pc_out),
    .opcode_in(opcode_in), .opcode_out(opcode_out),
    .rd_addr_in(rd_addr_in), .rd_addr_out(rd_addr_out),
    .funct3_in(funct3_in), .funct3_out(funct3_out),
    .funct7_in(funct7_in), .funct7_out(funct7_out),
    .rs1_addr_in(rs1_addr_in), .rs1_addr_out(rs1_addr_out),
    .rs2_addr_in(rs2_addr_in), .rs2_addr_out(rs2_addr_out),
    .rs1_data_in(rs1_data_in), .rs2_data_in(rs2_data_in),
    .imm_in(imm_in), .imm_out(imm_out),
    .op1_sel_in(op1_sel_in), .op1_sel_out(op1_sel_out),
    .op2_sel_in(op2_sel_in), .op2_sel_out(op2_sel_out),
    .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
    .alu_mem_data(alu_mem_data), .wb_data(wb_data),
    .jal_en_in(jal_en_in), .jal_en_out(jal_en_out),
    .jalr_en_in(jalr_en_in), .jalr_en_out(jalr_en_out),
    .rs1_data_out(rs1_data_out), .rs2_data_out(rs2_data_out),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [2:0]  f3;
    logic        jal;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_xfer = -10;
  int   run_len = 0;
  int   n_xfer = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: a payload is consumed when out_valid && out_ready.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      exp_t e;
      n_xfer++;
      if (cyc == last_xfer + 1) run_len++;
      else run_len = 1;
      last_xfer = cyc;
      if (sb_q.size() == 0) begin
        chk("unexpected_xfer_pc", pc_out, 32'hFFFF_FFFF);
      end else begin
        e = sb_q.pop_front();
        chk("pc_out", pc_out, e.pc);
        chk("rd_addr_out", {27'd0, rd_addr_out}, {27'd0, e.rd});
        chk("rs1_data_out", rs1_data_out, e.rs1);
        chk("rs2_data_out", rs2_data_out, e.rs2);
        chk("imm_out", imm_out, e.imm);
        chk("funct3_out", {29'd0, funct3_out}, {29'd0, e.f3});
        chk("jal_en_out", {31'd0, jal_en_out}, {31'd0, e.jal});
      end
    end
  end

  task automatic drive(input logic [31:0] pc, input logic [4:0] rd,
                       input logic jal, input logic jalr);
    pc_in       = pc;
    rd_addr_in  = rd;
    opcode_in   = 7'h33;
    funct3_in   = pc[4:2];
    funct7_in   = 7'h20;
    rs1_addr_in = rd + 5'd1;
    rs2_addr_in = rd + 5'd2;
    imm_in      = ~pc;
    op1_sel_in  = 2'b01;
    op2_sel_in  = 2'b10;
    jal_en_in   = jal;
    jalr_en_in  = jalr;
    in_valid    = 1'b1;
  endtask

  // Issue one instruction, push its expected result once accepted.
  task automatic send(input logic [31:0] pc, input logic [4:0] rd,
                      input logic [31:0] r1, input logic [31:0] r2,
                      input logic [1:0] s1, input logic [1:0] s2,
                      input logic [31:0] am, input logic [31:0] wb,
                      input logic jal,
                      input logic [31:0] e1, input logic [31:0] e2);
    int   n;
    exp_t e;
    drive(pc, rd, jal, 1'b0);
    rs1_data_in  = r1;
    rs2_data_in  = r2;
    fwd_sel1     = s1;
    fwd_sel2     = s2;
    alu_mem_data = am;
    wb_data      = wb;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("send_in_ready_timeout", {31'd0, in_ready}, 32'd1);
    end else begin
      e.pc = pc; e.rd = rd; e.rs1 = e1; e.rs2 = e2;
      e.imm = ~pc; e.f3 = pc[4:2]; e.jal = jal;
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  // One idle cycle with out_ready=1: the slot must drain to a masked bubble.
  task automatic idle_check(input string tag);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_rd"}, {27'd0, rd_addr_out}, 32'd0);
    chk({tag, "_jal"}, {31'd0, jal_en_out}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    drive(32'h0, 5'd0, 1'b0, 1'b0);
    in_valid = 1'b0;
    rs1_data_in = '0; rs2_data_in = '0; fwd_sel1 = '0; fwd_sel2 = '0;
    alu_mem_data = '0; wb_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_pc_out", pc_out, 32'd0);
    chk("reset_stall_cnt", stall_cnt, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic capture
    send(32'h40, 5'd5, 32'h1111_1111, 32'h2222_2222, 2'b00, 2'b00,
         32'h0, 32'h0, 1'b0, 32'h1111_1111, 32'h2222_2222);
    // Forwarding from ALU/MEM and WB, then select 11 -> regfile
    send(32'h48, 5'd6, 32'h0000_0001, 32'h0000_0002, 2'b01, 2'b10,
         32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b1, 32'hDEAD_BEEF, 32'hCAFE_F00D);
    send(32'h4C, 5'd3, 32'h4444_4444, 32'h3333_3333, 2'b11, 2'b11,
         32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b0, 32'h4444_4444, 32'h3333_3333);
    idle_check("drain");

    // Stall: hold pc 40 for three cycles while pc 44 waits
    out_ready = 1'b0;
    send(32'h40, 5'd5, 32'h1111_1111, 32'h2222_2222, 2'b01, 2'b00,
         32'hDEAD_BEEF, 32'h0, 1'b0, 32'hDEAD_BEEF, 32'h2222_2222);
    drive(32'h44, 5'd8, 1'b0, 1'b0);
    rs1_data_in = 32'h5555_5555;
    fwd_sel1    = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_pc_out", pc_out, 32'h40);
      chk("stall_rs1_hold", rs1_data_out, 32'hDEAD_BEEF);
      alu_mem_data = 32'h1000_0000 + i;
      fwd_sel2     = 2'(i);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    fwd_sel2  = 2'b00;
    @(negedge clk);
    chk("unstall_in_ready", {31'd0, in_ready}, 32'd1);
    begin
      exp_t e;
      e.pc = 32'h44; e.rd = 5'd8; e.rs1 = 32'h5555_5555; e.rs2 = 32'h2222_2222;
      e.imm = ~32'h44; e.f3 = 3'b001; e.jal = 1'b0;
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("stall_cnt", stall_cnt, c_PERF ? 32'd3 : 32'd0);
    @(posedge clk); #1;
    chk("post_stall_valid", {31'd0, out_valid}, 32'd0);

    // Flush against an incoming capture
    drive(32'h60, 5'd7, 1'b1, 1'b0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_in_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_in_jal", {31'd0, jal_en_out}, 32'd0);
    chk("flush_in_rd", {27'd0, rd_addr_out}, 32'd0);
    chk("flush_cnt_1", flush_cnt, c_PERF ? 32'd1 : 32'd0);

    // Flush of a held instruction
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive(32'h80, 5'd9, 1'b0, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("held_valid", {31'd0, out_valid}, 32'd1);
    chk("held_rd", {27'd0, rd_addr_out}, 32'd9);
    chk("held_jalr", {31'd0, jalr_en_out}, 32'd1);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("flush_hold_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_hold_rd", {27'd0, rd_addr_out}, 32'd0);
    chk("flush_hold_jalr", {31'd0, jalr_en_out}, 32'd0);
    chk("flush_cnt_2", flush_cnt, c_PERF ? 32'd2 : 32'd0);
    chk("stall_cnt_5", stall_cnt, c_PERF ? 32'd5 : 32'd0);
    @(posedge clk); #1;

    // Back-to-back: PCs 0,4,8,C with no bubbles
    send(32'h0, 5'd10, 32'hA0A0_0000, 32'hB0B0_0000, 2'b00, 2'b00,
         32'h0, 32'h0, 1'b0, 32'hA0A0_0000, 32'hB0B0_0000);
    send(32'h4, 5'd11, 32'hA0A0_0004, 32'hB0B0_0004, 2'b00, 2'b01,
         32'h7777_0004, 32'h0, 1'b1, 32'hA0A0_0004, 32'h7777_0004);
    send(32'h8, 5'd12, 32'hA0A0_0008, 32'hB0B0_0008, 2'b10, 2'b00,
         32'h0, 32'h8888_0008, 1'b0, 32'h8888_0008, 32'hB0B0_0008);
    send(32'hC, 5'd0, 32'hA0A0_000C, 32'hB0B0_000C, 2'b00, 2'b00,
         32'h0, 32'h0, 1'b0, 32'hA0A0_000C, 32'hB0B0_000C);
    idle_check("b2b_drain");
    chk("b2b_run_len", run_len, 32'd4);
    chk("xfer_count", n_xfer, 32'd9);
    chk("scoreboard_empty", sb_q.size(), 32'd0);

    // Asynchronous reset mid-stream with a held payload
    out_ready = 1'b0;
    drive(32'hC0, 5'd10, 1'b1, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pre_reset_valid", {31'd0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_valid", {31'd0, out_valid}, 32'd0);
    chk("async_reset_pc", pc_out, 32'd0);
    chk("async_reset_rd", {27'd0, rd_addr_out}, 32'd0);
    chk("async_reset_jal", {31'd0, jal_en_out}, 32'd0);
    chk("async_reset_stall", stall_cnt, 32'd0);
    chk("async_reset_flush", flush_cnt, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
